tdc_result_tx: RTL and testbench

- Return path to the host for TDC measurements.
- Accepts 24-bit TDC results and buffers them in a small FIFO.
- Serialises each result as a BYTES-long frame, MSB byte first, into the board UART transmitter using its new_tx_data/tx_busy handshake.
- Obeys the host pause/flush controls issued by the command decoder. Sits between the TDC readout logic and the UART TX.

---
 rtl/tdc_result_tx.sv | 116 +++++++++++
 tb/tb_tdc_result_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_result_tx.sv
// Buffers 24-bit TDC results in a small FIFO and streams each one to the
// board UART as a BYTES-long frame, MSB byte first, obeying host pause/flush.
module tdc_result_tx #(
  parameter int BYTES   = 3,
  parameter int FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*BYTES-1:0]   meas_data,
  input  logic                 meas_valid,
  input  logic                 pause,
  input  logic                 flush,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  output logic                 overflow,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 frame_active
);

  localparam int W     = 8 * BYTES;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BYTES + 1);

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CW-1:0]    LAST_C  = CW'(BYTES);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state, state_nxt;
  logic [W-1:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [W-1:0]         shift;
  logic [CW-1:0]        byte_cnt;

  logic full, wr_req, push, pop, drop_full, send_byte;

  // A full FIFO still accepts a write when the head is leaving in the same cycle.
  assign full      = (fifo_count == DEPTH_C);
  assign pop       = (state == IDLE) && !pause && (fifo_count != '0) && !flush;
  assign wr_req    = meas_valid && !pause && !flush;
  assign push      = wr_req && (!full || pop);
  assign drop_full = wr_req && full && !pop;
  assign send_byte = (state == SEND) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop_full) overflow <= 1'b1;
    end
  end

  // NOTE: storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= meas_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop)       state_nxt = SEND;
      SEND:    if (!tx_busy)  state_nxt = GAP;
      GAP:     state_nxt = (byte_cnt == LAST_C) ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_active = (state != IDLE);
  end

  // The GAP cycle after every strobe keeps new_tx_data one cycle wide
  // and gives the UART time to raise tx_busy before the next byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift       <= '0;
      byte_cnt    <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      if (pop) begin
        shift    <= mem[rd_ptr];
        byte_cnt <= '0;
      end else if (send_byte) begin
        tx_data     <= shift[W-1 -: 8];
        new_tx_data <= 1'b1;
        shift       <= shift << 8;
        byte_cnt    <= byte_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tdc_result_tx.sv
// Directed bench for tdc_result_tx: a timing-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_tdc_result_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] meas_data;
  logic        meas_valid;
  logic        pause;
  logic        flush;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        overflow;
  logic [2:0]  fifo_count;
  logic        frame_active;

  tdc_result_tx #(.BYTES(3), .FIFO_AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .meas_data    (meas_data),
    .meas_valid   (meas_valid),
    .pause        (pause),
    .flush        (flush),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .new_tx_data  (new_tx_data),
    .overflow     (overflow),
    .fifo_count   (fifo_count),
    .frame_active (frame_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART stand-in: busy for 10 cycles after every strobe, or held busy on demand.
  int busy_cnt = 0;
  bit force_busy = 0;
  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (new_tx_data === 1'b1) busy_cnt = 10;
    else if (busy_cnt > 0)    busy_cnt--;
  end

  // Model: queue of stored results, sticky overflow, and a frame described by
  // bytes left and the earliest edge at which the next byte may be launched.
  logic [23:0] mq[$];
  bit          m_ovf, m_active, m_strobe, pop_now, wr;
  logic [23:0] m_word;
  logic [7:0]  m_data;
  int          m_left, m_elig, sz;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_active = 0; m_strobe = 0; m_left = 0; m_data = 8'h00;
    end else begin
      sz = mq.size();
      pop_now = 0;
      m_strobe = 0;
      if (m_active) begin
        if (m_left > 0 && cyc >= m_elig && !tx_busy) begin
          m_strobe = 1;
          m_data   = m_word[23:16];
          m_word   = {m_word[15:0], 8'h00};
          m_left--;
          m_elig   = cyc + 2;
        end else if (m_left == 0 && cyc >= m_elig - 1) begin
          m_active = 0;
        end
      end else if (!pause && sz > 0 && !flush) begin
        pop_now  = 1;
        m_word   = mq.pop_front();
        m_left   = 3;
        m_active = 1;
        m_elig   = cyc + 1;
      end
      wr = meas_valid && !pause && !flush;
      if (flush) begin
        mq.delete();
        m_ovf = 0;
      end else if (wr) begin
        if (sz < 4 || pop_now) mq.push_back(meas_data);
        else                   m_ovf = 1;
      end
    end
  end

  logic [7:0] log_b[$];
  int         log_c[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      check("new_tx_data",  new_tx_data,  m_strobe);
      check("tx_data",      tx_data,      m_data);
      check("fifo_count",   fifo_count,   mq.size());
      check("overflow",     overflow,     m_ovf);
      check("frame_active", frame_active, m_active);
      if (new_tx_data === 1'b1) begin
        log_b.push_back(tx_data);
        log_c.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [23:0] w);
    meas_data  = w;
    meas_valid = 1'b1;
    @(negedge clk);
    meas_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (log_b.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (log_b.size() < n) check("timeout waiting for bytes", log_b.size(), n);
  endtask

  task automatic wait_quiet(input int budget);
    int k = 0;
    while ((m_active || tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (m_active || tx_busy) check("timeout waiting for idle", {m_active, tx_busy}, 0);
  endtask

  logic [23:0] t2w [5] = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0, 24'hD0E0F0};
  logic [23:0] t5w [5] = '{24'h13579B, 24'h2468AC, 24'h0F0F0F, 24'hF0F0F0, 24'h55AA55};

  initial begin
    int v, k;
    rst = 1'b1; meas_data = '0; meas_valid = 1'b0; pause = 1'b0; flush = 1'b0;
    @(negedge clk);
    cmp_en = 1;
    @(negedge clk);
    check("reset tx_data",      tx_data,      0);
    check("reset new_tx_data",  new_tx_data,  0);
    check("reset overflow",     overflow,     0);
    check("reset fifo_count",   fifo_count,   0);
    check("reset frame_active", frame_active, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single result, UART busy 10 cycles per byte
    log_b.delete(); log_c.delete();
    v = cyc;
    send(24'hA1B2C3);
    wait_bytes(3, 200);
    check("t1 byte0", log_b[0], 8'hA1);
    check("t1 byte1", log_b[1], 8'hB2);
    check("t1 byte2", log_b[2], 8'hC3);
    check("t1 first strobe latency", log_c[0] - v, 3);
    check("t1 strobe spacing", log_c[1] - log_c[0], 11);
    wait_quiet(100);
    check("t1 overflow end",   overflow,   0);
    check("t1 fifo_count end", fifo_count, 0);

    // frame held by tx_busy, then five results back to back
    log_b.delete(); log_c.delete();
    force_busy = 1;
    send(24'h5A5A5A);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      meas_data = t2w[i]; meas_valid = 1'b1;
      @(negedge clk);
    end
    meas_valid = 1'b0;
    @(negedge clk);
    check("t2 fifo_count full", fifo_count, 4);
    check("t2 overflow set",    overflow,   1);
    check("t2 no bytes while busy", log_b.size(), 0);
    force_busy = 0;
    wait_bytes(15, 800);
    wait_quiet(100);
    repeat (20) @(negedge clk);
    check("t2 total bytes", log_b.size(), 15);
    check("t2 primed frame", log_b[0], 8'h5A);
    check("t2 4th queued byte0", log_b[12], 8'hA0);
    check("t2 4th queued byte2", log_b[14], 8'hC0);
    check("t2 overflow sticky", overflow, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush clears overflow", overflow, 0);

    // pause drops results silently
    log_b.delete(); log_c.delete();
    pause = 1'b1;
    send(24'h111111);
    @(negedge clk);
    send(24'h222222);
    repeat (10) @(negedge clk);
    check("t3 paused count",    fifo_count,   0);
    check("t3 paused overflow", overflow,     0);
    check("t3 paused strobes",  log_b.size(), 0);
    pause = 1'b0;
    send(24'h334455);
    wait_bytes(3, 200);
    check("t3 byte0", log_b[0], 8'h33);
    check("t3 byte2", log_b[2], 8'h55);
    wait_quiet(100);

    // pause mid-frame holds the queued result
    log_b.delete(); log_c.delete();
    send(24'hABCDEF);
    send(24'h123456);
    wait_bytes(2, 200);
    pause = 1'b1;
    wait_bytes(3, 200);
    repeat (30) @(negedge clk);
    check("t4 frame complete", log_b.size(), 3);
    check("t4 byte0", log_b[0], 8'hAB);
    check("t4 byte1", log_b[1], 8'hCD);
    check("t4 byte2", log_b[2], 8'hEF);
    check("t4 queued held", fifo_count, 1);
    pause = 1'b0;
    wait_bytes(6, 200);
    check("t4 queued byte0", log_b[3], 8'h12);
    check("t4 queued byte2", log_b[5], 8'h56);
    wait_quiet(100);

    // flush with overflow=1 and count=3 while a frame is in flight
    log_b.delete(); log_c.delete();
    force_busy = 1;
    send(24'hC0FFEE);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      meas_data = t5w[i]; meas_valid = 1'b1;
      @(negedge clk);
    end
    meas_valid = 1'b0;
    force_busy = 0;
    k = 0;
    while (mq.size() != 3 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t5 count before flush",    fifo_count, 3);
    check("t5 overflow before flush", overflow,   1);
    flush = 1'b1; meas_data = 24'hDEAD00; meas_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; meas_valid = 1'b0;
    check("t5 count after flush",    fifo_count, 0);
    check("t5 overflow after flush", overflow,   0);
    wait_bytes(6, 300);
    wait_quiet(100);
    repeat (20) @(negedge clk);
    check("t5 total bytes", log_b.size(), 6);
    check("t5 in-flight byte0", log_b[3], 8'h13);
    check("t5 in-flight byte2", log_b[5], 8'h9B);

    // reset after the first byte aborts the frame
    log_b.delete(); log_c.delete();
    send(24'h778899);
    wait_bytes(1, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 tx_data",      tx_data,      0);
    check("t6 new_tx_data",  new_tx_data,  0);
    check("t6 overflow",     overflow,     0);
    check("t6 fifo_count",   fifo_count,   0);
    check("t6 frame_active", frame_active, 0);
    repeat (60) @(negedge clk);
    check("t6 no further strobes", log_b.size(), 1);
    check("t6 first byte", log_b[0], 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
